// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the UART link checker and generator.
package crc_pkg;

    localparam int          DEF_CRC_SIZE = 32;
    localparam logic [31:0] DEF_POLY     = 32'hEDB88320;
    localparam logic [31:0] DEF_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] DEF_XOROUT   = 32'hFFFFFFFF;
    localparam int          DEF_LEN_W    = 16;

    typedef enum logic [1:0] {
        COLLECT,
        SHIFT,
        CHECK
    } state_t;

endpackage

// File: rtl/crc32_serial_core.sv
// Bit-serial CRC register, one bit per enabled cycle, MSB-first feedback.
module crc32_serial_core
    import crc_pkg::*;
#(
    parameter int                    CRC_SIZE = DEF_CRC_SIZE,
    parameter logic [CRC_SIZE-1:0]   POLY     = DEF_POLY,
    parameter logic [CRC_SIZE-1:0]   INIT     = DEF_INIT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                init,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic [CRC_SIZE-1:0] crc
);

    // Reload on reset or frame restart, otherwise fold in one bit when offered
    always_ff @(posedge CLK) begin
        if (RST || init) begin
            crc <= INIT;
        end else if (bit_valid) begin
            crc <= {crc[CRC_SIZE-2:0], 1'b0} ^ ((crc[CRC_SIZE-1] ^ bit_in) ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: hashes payload bytes bit-serially and
// compares against the four trailing CRC bytes, one verdict pulse per frame.
module crc32_frame_checker
    import crc_pkg::*;
#(
    parameter int                  CRC_SIZE = DEF_CRC_SIZE,
    parameter logic [CRC_SIZE-1:0] POLY     = DEF_POLY,
    parameter logic [CRC_SIZE-1:0] INIT     = DEF_INIT,
    parameter logic [CRC_SIZE-1:0] XOROUT   = DEF_XOROUT,
    parameter int                  LEN_W    = DEF_LEN_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                out_valid,
    output logic                out_ok,
    output logic                out_err_short,
    output logic [LEN_W-1:0]    out_len,
    output logic [CRC_SIZE-1:0] out_crc_calc,
    output logic [CRC_SIZE-1:0] out_crc_rx
);

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         dl_word;
    logic [2:0]          fill;
    logic [7:0]          shift_reg;
    logic [2:0]          bit_cnt;
    logic                last_pend;
    logic [LEN_W-1:0]    len;
    logic                bit_valid;
    logic                crc_init;
    logic [CRC_SIZE-1:0] crc;
    logic [CRC_SIZE-1:0] crc_final;
    logic                ok_now;
    logic                err_now;
    logic                held_ok;
    logic                held_err;
    logic [LEN_W-1:0]    held_len;
    logic [CRC_SIZE-1:0] held_calc;
    logic [CRC_SIZE-1:0] held_rx;
    logic                accept;

    crc32_serial_core #(
        .CRC_SIZE (CRC_SIZE),
        .POLY     (POLY),
        .INIT     (INIT)
    ) u_core (
        .CLK       (CLK),
        .RST       (RST),
        .init      (crc_init),
        .bit_valid (bit_valid),
        .bit_in    (shift_reg[7]),
        .crc       (crc)
    );

    assign accept    = in_valid && in_ready;
    assign crc_final = crc ^ XOROUT;
    assign err_now   = (fill != 3'd4);
    assign ok_now    = !err_now && (crc_final == dl_word);

    // During the check cycle the live verdict is shown, afterwards the captured copy holds
    assign out_ok        = (state == CHECK) ? ok_now    : held_ok;
    assign out_err_short = (state == CHECK) ? err_now   : held_err;
    assign out_len       = (state == CHECK) ? len       : held_len;
    assign out_crc_calc  = (state == CHECK) ? crc_final : held_calc;
    assign out_crc_rx    = (state == CHECK) ? dl_word   : held_rx;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake, shift enable and verdict strobe
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bit_valid = 1'b0;
        crc_init  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (fill == 3'd4) begin
                        state_nxt = SHIFT;
                    end else if (in_last) begin
                        state_nxt = CHECK;
                    end
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                if (bit_cnt == 3'd7) begin
                    state_nxt = last_pend ? CHECK : COLLECT;
                end
            end
            CHECK: begin
                out_valid = 1'b1;
                crc_init  = 1'b1;
                state_nxt = COLLECT;
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    // Delay line, shift register, counters and verdict capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            dl_word   <= '0;
            fill      <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            last_pend <= 1'b0;
            len       <= '0;
            held_ok   <= 1'b0;
            held_err  <= 1'b0;
            held_len  <= '0;
            held_calc <= '0;
            held_rx   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (fill != 3'd4) begin
                            case (fill[1:0])
                                2'd0:    dl_word[31:24] <= in_data;
                                2'd1:    dl_word[23:16] <= in_data;
                                2'd2:    dl_word[15:8]  <= in_data;
                                default: dl_word[7:0]   <= in_data;
                            endcase
                            fill <= fill + 3'd1;
                        end else begin
                            shift_reg <= dl_word[31:24];
                            dl_word   <= {dl_word[23:0], in_data};
                            bit_cnt   <= '0;
                            last_pend <= in_last;
                            if (len != '1) begin
                                len <= len + LEN_W'(1);
                            end
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                CHECK: begin
                    held_ok   <= ok_now;
                    held_err  <= err_now;
                    held_len  <= len;
                    held_calc <= crc_final;
                    held_rx   <= dl_word;
                    dl_word   <= '0;
                    fill      <= '0;
                    len       <= '0;
                    last_pend <= 1'b0;
                end
                default: begin
                    fill <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker: frame-level reference model
// plus directed frames with hand-computed results.
module tb_crc32_frame_checker;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ok;
    logic        out_err_short;
    logic [15:0] out_len;
    logic [31:0] out_crc_calc;
    logic [31:0] out_crc_rx;

    int checks   = 0;
    int failures = 0;

    crc32_frame_checker dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ok        (out_ok),
        .out_err_short (out_err_short),
        .out_len       (out_len),
        .out_crc_calc  (out_crc_calc),
        .out_crc_rx    (out_crc_rx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0]  frame_q [$];
    logic [7:0]  txq [$];
    bit          model_live = 0;
    bit          took = 0;
    int          cyc = 0;
    int          ready_at = 0;
    int          verdict_at = -1;
    int          verdicts = 0;
    logic        p_ok, p_err, e_ok, e_err;
    logic [15:0] p_len, e_len;
    logic [31:0] p_calc, p_rx, e_calc, e_rx;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // CRC of a byte sequence straight from the bit-step rule, final XOR applied
    function automatic logic [31:0] crcModel(input logic [7:0] data [$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (data[i]) begin
            for (int k = 7; k >= 0; k--) begin
                if (c[31] ^ data[i][k]) c = (c << 1) ^ 32'hEDB88320;
                else                    c = c << 1;
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    // Frame-level verdict: everything but the last four bytes is payload
    task automatic computeVerdict();
        logic [7:0] payload [$];
        int n;
        n = frame_q.size();
        p_rx = '0;
        payload.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) p_rx = p_rx | (32'(frame_q[i]) << (24 - 8 * i));
            p_err  = 1'b1;
            p_ok   = 1'b0;
            p_len  = 16'd0;
            p_calc = 32'h0;
        end else begin
            for (int i = 0; i < n - 4; i++) payload.push_back(frame_q[i]);
            for (int i = 0; i < 4; i++) p_rx = p_rx | (32'(frame_q[n - 4 + i]) << (24 - 8 * i));
            p_err  = 1'b0;
            p_len  = (n - 4 > 65535) ? 16'hFFFF : 16'(n - 4);
            p_calc = crcModel(payload);
            p_ok   = (p_calc == p_rx);
        end
    endtask

    // Compare process: checks every output each cycle, then advances the model
    always @(negedge CLK) begin
        if (model_live) begin
            if (cyc == verdict_at) begin
                e_ok = p_ok; e_err = p_err; e_len = p_len; e_calc = p_calc; e_rx = p_rx;
            end
            checkOutput("in_ready", 32'(in_ready), 32'(cyc >= ready_at));
            checkOutput("out_valid", 32'(out_valid), 32'(cyc == verdict_at));
            checkOutput("out_ok", 32'(out_ok), 32'(e_ok));
            checkOutput("out_err_short", 32'(out_err_short), 32'(e_err));
            checkOutput("out_len", 32'(out_len), 32'(e_len));
            checkOutput("out_crc_calc", out_crc_calc, e_calc);
            checkOutput("out_crc_rx", out_crc_rx, e_rx);
            if (cyc == verdict_at) verdicts++;
        end
        if (RST) begin
            model_live = 1;
            frame_q.delete();
            ready_at   = cyc + 1;
            verdict_at = -1;
            e_ok = 0; e_err = 0; e_len = 0; e_calc = 0; e_rx = 0;
        end else if (model_live && in_valid && cyc >= ready_at) begin
            frame_q.push_back(in_data);
            took = 1;
            ready_at = (frame_q.size() > 4) ? cyc + 9 : cyc + 1;
            if (in_last) begin
                computeVerdict();
                verdict_at = (frame_q.size() > 4) ? cyc + 9 : cyc + 1;
                ready_at   = verdict_at + 1;
                frame_q.delete();
            end
        end
        cyc++;
    end

    // Offer one byte, optionally after idle cycles, and hold it until accepted
    task automatic applyStimulus(input logic [7:0] d, input logic l, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge CLK); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        took     = 0;
        n        = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!took && n < 100);
        checkOutput("handshake", 32'(took), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic sendFrame(input int gap);
        int v0, n;
        v0 = verdicts;
        foreach (txq[i]) applyStimulus(txq[i], (i == txq.size() - 1), gap);
        n = 0;
        while (verdicts == v0 && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput("verdict_seen", 32'(verdicts > v0), 32'd1);
    endtask

    task automatic loadBytes(input logic [63:0] v, input int n);
        txq.delete();
        for (int i = 0; i < n; i++) txq.push_back(v[8 * (n - 1 - i) +: 8]);
    endtask

    task automatic appendCrc();
        logic [31:0] c;
        c = crcModel(txq);
        txq.push_back(c[31:24]);
        txq.push_back(c[23:16]);
        txq.push_back(c[15:8]);
        txq.push_back(c[7:0]);
    endtask

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_len", 32'(out_len), 32'd0);
        checkOutput("rst_crc_calc", out_crc_calc, 32'd0);

        $display("[TB] all-zero frame");
        loadBytes(64'h00000000, 4);
        sendFrame(0);
        checkOutput("t1_ok", 32'(out_ok), 32'd1);
        checkOutput("t1_calc", out_crc_calc, 32'd0);
        checkOutput("t1_len", 32'(out_len), 32'd0);
        checkOutput("t1_err", 32'(out_err_short), 32'd0);

        $display("[TB] empty payload, wrong crc");
        loadBytes(64'h00000001, 4);
        sendFrame(1);
        checkOutput("t2_ok", 32'(out_ok), 32'd0);
        checkOutput("t2_rx", out_crc_rx, 32'h00000001);
        checkOutput("t2_calc", out_crc_calc, 32'd0);

        $display("[TB] single zero payload byte, hand-computed crc");
        loadBytes(64'h00EADF065F, 5);
        sendFrame(0);
        checkOutput("pin_ok", 32'(out_ok), 32'd1);
        checkOutput("pin_len", 32'(out_len), 32'd1);
        checkOutput("pin_calc", out_crc_calc, 32'hEADF065F);

        $display("[TB] payload A5 3C with good crc, then one bit flipped");
        loadBytes(64'hA53C, 2);
        appendCrc();
        sendFrame(0);
        checkOutput("t3_ok", 32'(out_ok), 32'd1);
        checkOutput("t3_len", 32'(out_len), 32'd2);
        txq[0] = 8'hA4;
        sendFrame(0);
        checkOutput("t3_flip_ok", 32'(out_ok), 32'd0);

        $display("[TB] short frame then normal frame");
        loadBytes(64'hAABB, 2);
        sendFrame(0);
        checkOutput("t4_err", 32'(out_err_short), 32'd1);
        checkOutput("t4_ok", 32'(out_ok), 32'd0);
        checkOutput("t4_rx", out_crc_rx, 32'hAABB0000);
        loadBytes(64'h1122, 2);
        appendCrc();
        sendFrame(0);
        checkOutput("t4_next_ok", 32'(out_ok), 32'd1);
        checkOutput("t4_next_err", 32'(out_err_short), 32'd0);

        $display("[TB] back-to-back 6-byte frame");
        loadBytes(64'h5AC3, 2);
        appendCrc();
        sendFrame(0);
        checkOutput("t5_ok", 32'(out_ok), 32'd1);

        $display("[TB] reset during payload shift");
        for (int i = 0; i < 7; i++) applyStimulus(8'(8'h30 + i), 1'b0, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_out_len", 32'(out_len), 32'd0);
        loadBytes(64'h0102030405, 5);
        appendCrc();
        sendFrame(1);
        checkOutput("t6_ok", 32'(out_ok), 32'd1);
        checkOutput("t6_len", 32'(out_len), 32'd5);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            int plen;
            txq.delete();
            plen = $urandom_range(0, 8);
            for (int i = 0; i < plen; i++) txq.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                appendCrc();
                if ($urandom_range(0, 3) == 0) txq[$urandom_range(0, txq.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            end else begin
                int extra;
                extra = $urandom_range(1, 4);
                for (int i = 0; i < extra; i++) txq.push_back(8'($urandom));
            end
            sendFrame($urandom_range(0, 2));
        end

        repeat (5) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
